// File: rtl/viterbi_enc_dec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder and a 4-state hard-decision
// Viterbi decoder with register-exchange survivors; the two paths are independent.
module viterbi_enc_dec #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_i,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_o,
    input  logic       dec_enable_i,
    input  logic [1:0] dec_d_i,
    output logic       dec_d_o
);

    localparam int L  = TB_DEPTH;
    localparam int SW = PM_W + 1;
    localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
    localparam logic [SW-1:0]   PM_SAT  = {1'b0, PM_MAX};

    // ---------------- encoder ----------------
    logic [1:0] enc_state_reg;
    logic [1:0] enc_sym_reg;
    logic       enc_valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_state_reg <= 2'b00;
            enc_sym_reg   <= 2'b00;
            enc_valid_reg <= 1'b0;
        end else if (enc_enable_i) begin
            enc_sym_reg   <= {enc_d_i ^ enc_state_reg[1] ^ enc_state_reg[0],
                              enc_d_i ^ enc_state_reg[0]};
            enc_state_reg <= {enc_d_i, enc_state_reg[1]};
            enc_valid_reg <= 1'b1;
        end else begin
            enc_valid_reg <= 1'b0;
        end
    end

    assign enc_d_o     = enc_sym_reg;
    assign enc_valid_o = enc_valid_reg;

    // ---------------- decoder ----------------
    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    // The oldest survivor bit is only ever needed at the output, so each
    // stored survivor keeps L-1 bits and the full L-bit path exists in sv_next.
    logic [3:0][PM_W-1:0] pm_reg;
    logic [3:0][L-2:0]    sv_reg;
    logic                 dec_bit_reg;

    logic [3:0][SW-1:0]   acs_pm;
    logic [3:0]           sel_hi;
    logic [3:0][L-1:0]    sv_next;
    logic [3:0][PM_W-1:0] pm_next;
    logic [SW-1:0]        min_pm;
    logic [1:0]           best_state;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_acs
            // Next state {d,a}; predecessors {a,0} (lower) and {a,1} (upper).
            localparam int D = gi / 2;
            localparam int A = gi % 2;
            localparam logic [1:0] SYM_LO = {1'(D ^ A), 1'(D)};
            localparam logic [1:0] SYM_HI = {1'(D ^ A ^ 1), 1'(D ^ 1)};

            logic [SW-1:0] cand_lo;
            logic [SW-1:0] cand_hi;
            logic [SW-1:0] diff;

            assign cand_lo = {1'b0, pm_reg[2*A]}
                           + {{(SW-2){1'b0}}, hamming(dec_d_i, SYM_LO)};
            assign cand_hi = {1'b0, pm_reg[2*A+1]}
                           + {{(SW-2){1'b0}}, hamming(dec_d_i, SYM_HI)};
            assign sel_hi[gi]  = (cand_hi < cand_lo);
            assign acs_pm[gi]  = sel_hi[gi] ? cand_hi : cand_lo;
            assign sv_next[gi] = {(sel_hi[gi] ? sv_reg[2*A+1] : sv_reg[2*A]), 1'(D)};
            assign diff        = acs_pm[gi] - min_pm;
            assign pm_next[gi] = (diff > PM_SAT) ? PM_MAX : diff[PM_W-1:0];
        end
    endgenerate

    // Strict compare keeps ties on the lowest-index state.
    always_comb begin
        min_pm     = acs_pm[0];
        best_state = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (acs_pm[i] < min_pm) begin
                min_pm     = acs_pm[i];
                best_state = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_reg      <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
            sv_reg      <= '0;
            dec_bit_reg <= 1'b0;
        end else if (dec_enable_i) begin
            pm_reg <= pm_next;
            for (int i = 0; i < 4; i++) begin
                sv_reg[i] <= sv_next[i][L-2:0];
            end
            dec_bit_reg <= sv_next[best_state][L-1];
        end
    end

    assign dec_d_o = dec_bit_reg;

endmodule

// File: tb/tb_viterbi_enc_dec.sv
// Directed bench for viterbi_enc_dec: reset, encoder vectors, and loopback
// decoding through a registered channel with optional bit flips.
module tb_viterbi_enc_dec;

    localparam int L = 16;

    logic       clk;
    logic       rst;
    logic       enc_enable_i;
    logic       enc_d_i;
    logic       enc_valid_o;
    logic [1:0] enc_d_o;
    logic       dec_enable_i;
    logic [1:0] dec_d_i;
    logic       dec_d_o;

    viterbi_enc_dec #(.TB_DEPTH(L), .PM_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_i      (enc_d_i),
        .enc_valid_o  (enc_valid_o),
        .enc_d_o      (enc_d_o),
        .dec_enable_i (dec_enable_i),
        .dec_d_i      (dec_d_i),
        .dec_d_o      (dec_d_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    logic bits [512];
    int   enc_k;
    int   acc_k;
    logic exp_dec;
    int   mode;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock: drive encoder, check decoder, then register the channel.
    task automatic run_cycle(input logic en, input logic d);
        logic [1:0] flip;
        int j;
        enc_enable_i = en;
        enc_d_i      = d;
        @(posedge clk);
        #1;
        if (dec_enable_i) begin
            if (acc_k >= L - 1) exp_dec = bits[acc_k-(L-1)];
            else                exp_dec = 1'b0;
            acc_k++;
        end
        chk($sformatf("dec_d_o k=%0d", acc_k), dec_d_o, exp_dec);
        if (en) begin
            bits[enc_k] = d;
            enc_k++;
        end
        flip = 2'b00;
        j = enc_k - 1;
        if (enc_valid_o && mode == 1 && (j % 8) == 1)  flip = 2'b10;
        if (enc_valid_o && mode == 2 && (j % 64) == 20) flip = 2'b01;
        if (enc_valid_o && mode == 2 && (j % 64) == 21) flip = 2'b10;
        dec_d_i      = enc_d_o ^ flip;
        dec_enable_i = enc_valid_o;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic apply_reset();
        rst          = 1'b0;
        enc_enable_i = 1'b0;
        enc_d_i      = 1'b0;
        dec_enable_i = 1'b0;
        dec_d_i      = 2'b00;
        #2;
        chk("async_rst enc_d_o", enc_d_o, 2'b00);
        chk("async_rst enc_valid_o", enc_valid_o, 2'b00);
        chk("async_rst dec_d_o", dec_d_o, 2'b00);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        enc_k   = 0;
        acc_k   = 0;
        exp_dec = 1'b0;
        mode    = 0;
    endtask

    task automatic loopback(input int m);
        apply_reset();
        mode = m;
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                repeat (5) run_cycle(1'b0, 1'b0);
            end
            run_cycle(1'b1, 1'($urandom));
        end
        repeat (3) run_cycle(1'b0, 1'b0);
    endtask

    logic       seq_d [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] seq_s [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

    initial begin
        rst          = 1'b0;
        enc_enable_i = 1'b1;
        enc_d_i      = 1'b1;
        dec_enable_i = 1'b0;
        dec_d_i      = 2'b00;
        enc_k        = 0;
        acc_k        = 0;
        exp_dec      = 1'b0;
        mode         = 0;

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("in_rst enc_d_o", enc_d_o, 2'b00);
            chk("in_rst enc_valid_o", enc_valid_o, 2'b00);
            chk("in_rst dec_d_o", dec_d_o, 2'b00);
        end
        rst = 1'b1;
        run_cycle(1'b1, 1'b1);
        chk("first enc_d_o", enc_d_o, 2'b11);
        chk("first enc_valid_o", enc_valid_o, 2'b01);
        run_cycle(1'b1, 1'b0);

        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, seq_d[i]);
            chk($sformatf("seq enc_d_o i=%0d", i), enc_d_o, seq_s[i]);
            chk($sformatf("seq enc_valid_o i=%0d", i), enc_valid_o, 2'b01);
        end
        run_cycle(1'b0, 1'b0);
        chk("idle enc_valid_o", enc_valid_o, 2'b00);
        chk("idle enc_d_o hold", enc_d_o, 2'b11);

        loopback(0);
        loopback(1);
        loopback(2);
        apply_reset();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
